// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the two-master external bus arbiter:
// FSM state encoding, the "no bytes written" strobe value and the default fairness limit.
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_e;

    localparam logic [3:0] STROBE_NONE = 4'h0;

    localparam int DEFAULT_STARVE_LIMIT = 4;

endpackage

// File: rtl/bus_arbiter_fairness_counter.sv
// Saturating counter of consecutive data grants taken while a fetch was waiting.
// at_limit tells the arbiter it must hand the next contested slot to the fetch port.
// LIMIT must be at least 1.
module arb_fairness_counter #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam int W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] LIMIT_W = W'(LIMIT);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Clear has priority so a fetch grant always restarts the window; increments stop at LIMIT.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != LIMIT_W)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign at_limit = (count_q == LIMIT_W);

endmodule

// File: rtl/bus_arbiter.sv
// Registered arbiter between the instruction and data ports and the single external bus.
// A granted request's payload is latched so ext_* stay stable for the whole transaction;
// the slave's ready/read data are steered back combinationally to the granted master only.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        i_valid,
    input  logic [31:0] i_address,
    output logic        i_ready,
    output logic [31:0] i_read_data,

    input  logic        d_valid,
    input  logic [31:0] d_address,
    input  logic [31:0] d_write_data,
    input  logic [3:0]  d_write_strobe,
    output logic        d_ready,
    output logic [31:0] d_read_data,

    output logic        ext_valid,
    output logic        ext_instruction,
    input  logic        ext_ready,
    output logic [31:0] ext_address,
    output logic [31:0] ext_write_data,
    output logic [3:0]  ext_write_strobe,
    input  logic [31:0] ext_read_data
);

    arb_state_e  state_q;
    logic        extValid_q;
    logic        extInstruction_q;
    logic [31:0] extAddress_q;
    logic [31:0] extWriteData_q;
    logic [3:0]  extWriteStrobe_q;

    logic grantData;
    logic grantInstr;
    logic starveAtLimit;

    // Data wins contested slots until the fetch port has been passed over STARVE_LIMIT times.
    always_comb begin
        grantData  = 1'b0;
        grantInstr = 1'b0;
        if (state_q == IDLE) begin
            if (d_valid && !(i_valid && starveAtLimit)) begin
                grantData = 1'b1;
            end else if (i_valid) begin
                grantInstr = 1'b1;
            end
        end
    end

    arb_fairness_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_fairness (
        .clk      (clk),
        .reset    (reset),
        .inc      (grantData && i_valid),
        .clr      (grantInstr),
        .at_limit (starveAtLimit)
    );

    // Arbitration FSM; payload is captured on the grant edge and the bus always drops
    // back to IDLE for one cycle after a completion so masters can retire or renew valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= IDLE;
            extValid_q       <= 1'b0;
            extInstruction_q <= 1'b0;
            extAddress_q     <= '0;
            extWriteData_q   <= '0;
            extWriteStrobe_q <= STROBE_NONE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grantData) begin
                        state_q          <= BUSY_D;
                        extValid_q       <= 1'b1;
                        extInstruction_q <= 1'b0;
                        extAddress_q     <= d_address;
                        extWriteData_q   <= d_write_data;
                        extWriteStrobe_q <= d_write_strobe;
                    end else if (grantInstr) begin
                        // Fetches never write: no store data and an all-zero strobe.
                        state_q          <= BUSY_I;
                        extValid_q       <= 1'b1;
                        extInstruction_q <= 1'b1;
                        extAddress_q     <= i_address;
                        extWriteData_q   <= '0;
                        extWriteStrobe_q <= STROBE_NONE;
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (ext_ready) begin
                        state_q    <= IDLE;
                        extValid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    extValid_q <= 1'b0;
                end
            endcase
        end
    end

    // Route the completion to the granted master only; a reset in the same cycle suppresses it.
    always_comb begin
        i_ready     = 1'b0;
        d_ready     = 1'b0;
        i_read_data = '0;
        d_read_data = '0;
        if (!reset && ext_ready) begin
            if (state_q == BUSY_I) begin
                i_ready     = 1'b1;
                i_read_data = ext_read_data;
            end else if (state_q == BUSY_D) begin
                d_ready     = 1'b1;
                d_read_data = ext_read_data;
            end
        end
    end

    assign ext_valid        = extValid_q;
    assign ext_instruction  = extInstruction_q;
    assign ext_address      = extAddress_q;
    assign ext_write_data   = extWriteData_q;
    assign ext_write_strobe = extWriteStrobe_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: master and slave processes drive the ports, the main
// sequence queues hand-computed grants and responses, and a monitor checks them as they appear.
module tb_bus_arbiter;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strobe;
        int          hold;
        int          alter;
    } req_t;

    typedef struct {
        bit          instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strobe;
    } grant_t;

    typedef struct {
        bit          instr;
        logic [31:0] data;
    } resp_t;

    logic        clk;
    logic        reset;
    logic        i_valid;
    logic [31:0] i_address;
    logic        i_ready;
    logic [31:0] i_read_data;
    logic        d_valid;
    logic [31:0] d_address;
    logic [31:0] d_write_data;
    logic [3:0]  d_write_strobe;
    logic        d_ready;
    logic [31:0] d_read_data;
    logic        ext_valid;
    logic        ext_instruction;
    logic        ext_ready;
    logic [31:0] ext_address;
    logic [31:0] ext_write_data;
    logic [3:0]  ext_write_strobe;
    logic [31:0] ext_read_data;

    req_t   iReqQ[$];
    req_t   dReqQ[$];
    grant_t expGrantQ[$];
    resp_t  expRespQ[$];

    int total;
    int bad;
    int slaveMode;
    int slaveDelay;

    bus_arbiter #(
        .STARVE_LIMIT (4)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .i_valid          (i_valid),
        .i_address        (i_address),
        .i_ready          (i_ready),
        .i_read_data      (i_read_data),
        .d_valid          (d_valid),
        .d_address        (d_address),
        .d_write_data     (d_write_data),
        .d_write_strobe   (d_write_strobe),
        .d_ready          (d_ready),
        .d_read_data      (d_read_data),
        .ext_valid        (ext_valid),
        .ext_instruction  (ext_instruction),
        .ext_ready        (ext_ready),
        .ext_address      (ext_address),
        .ext_write_data   (ext_write_data),
        .ext_write_strobe (ext_write_strobe),
        .ext_read_data    (ext_read_data)
    );

    // Free-running clock, rising edge at 5 ns.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something wedges beyond every bounded wait.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] respData(input logic [31:0] addr);
        return {addr[15:0], 16'h0013};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic reportFail(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s: got event expected none/other", name);
    endtask

    task automatic applyStimulus(input bit isInstr, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] strobe, input int hold, input int alter);
        req_t r;
        r.addr   = addr;
        r.wdata  = wdata;
        r.strobe = strobe;
        r.hold   = hold;
        r.alter  = alter;
        if (isInstr) iReqQ.push_back(r);
        else         dReqQ.push_back(r);
    endtask

    task automatic expectGrant(input bit instr, input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strobe);
        grant_t g;
        g.instr  = instr;
        g.addr   = addr;
        g.wdata  = wdata;
        g.strobe = strobe;
        expGrantQ.push_back(g);
    endtask

    task automatic expectResp(input bit instr, input logic [31:0] data);
        resp_t r;
        r.instr = instr;
        r.data  = data;
        expRespQ.push_back(r);
    endtask

    task automatic checkAllIdle(input string tag);
        checkOutput({tag, "_ext_valid"},        32'(ext_valid),        32'h0);
        checkOutput({tag, "_ext_instruction"},  32'(ext_instruction),  32'h0);
        checkOutput({tag, "_ext_address"},      ext_address,           32'h0);
        checkOutput({tag, "_ext_write_data"},   ext_write_data,        32'h0);
        checkOutput({tag, "_ext_write_strobe"}, 32'(ext_write_strobe), 32'h0);
        checkOutput({tag, "_i_ready"},          32'(i_ready),          32'h0);
        checkOutput({tag, "_d_ready"},          32'(d_ready),          32'h0);
        checkOutput({tag, "_i_read_data"},      i_read_data,           32'h0);
        checkOutput({tag, "_d_read_data"},      d_read_data,           32'h0);
    endtask

    task automatic waitDrain(input string tag);
        int n;
        n = 0;
        while ((iReqQ.size() != 0 || dReqQ.size() != 0 || expGrantQ.size() != 0 || expRespQ.size() != 0
                || i_valid || d_valid || ext_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) reportFail({tag, "_drain_timeout"});
        repeat (2) @(negedge clk);
    endtask

    // Instruction master: holds valid and address until i_ready, then renews or drops.
    initial begin : masterI
        req_t r;
        int   n;
        i_valid   = 1'b0;
        i_address = '0;
        @(posedge clk); #1;
        forever begin
            if (iReqQ.size() > 0) begin
                r = iReqQ.pop_front();
                i_valid   = 1'b1;
                i_address = r.addr;
                if (r.hold > 0) begin
                    repeat (r.hold) @(posedge clk);
                    #1;
                end else begin
                    n = 0;
                    do begin
                        @(negedge clk);
                        n++;
                    end while (!i_ready && n < 200);
                    if (!i_ready) reportFail("masterI_timeout");
                    @(posedge clk); #1;
                end
            end else begin
                i_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
    end

    // Data master: same protocol; 'alter' deliberately disturbs the payload mid-transaction.
    initial begin : masterD
        req_t r;
        int   n;
        d_valid        = 1'b0;
        d_address      = '0;
        d_write_data   = '0;
        d_write_strobe = '0;
        @(posedge clk); #1;
        forever begin
            if (dReqQ.size() > 0) begin
                r = dReqQ.pop_front();
                d_valid        = 1'b1;
                d_address      = r.addr;
                d_write_data   = r.wdata;
                d_write_strobe = r.strobe;
                if (r.hold > 0) begin
                    repeat (r.hold) @(posedge clk);
                    #1;
                end else begin
                    n = 0;
                    do begin
                        @(negedge clk);
                        n++;
                        if (r.alter > 0 && n == r.alter) begin
                            d_address    = 32'h0000_1234;
                            d_write_data = 32'h5555_5555;
                        end
                    end while (!d_ready && n < 200);
                    if (!d_ready) reportFail("masterD_timeout");
                    @(posedge clk); #1;
                end
            end else begin
                d_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
    end

    // Slave: mode 0 answers after slaveDelay busy cycles, mode 1 holds ready high, mode 2 is silent.
    initial begin : slave
        int waitCnt;
        waitCnt       = 0;
        ext_ready     = 1'b0;
        ext_read_data = 32'hA5A5_A5A5;
        forever begin
            @(posedge clk); #2;
            ext_ready     = 1'b0;
            ext_read_data = 32'hA5A5_A5A5;
            if (slaveMode == 1) begin
                ext_ready = 1'b1;
            end else if (slaveMode == 0 && ext_valid) begin
                if (waitCnt >= slaveDelay) begin
                    ext_ready     = 1'b1;
                    ext_read_data = respData(ext_address);
                    waitCnt       = 0;
                end else begin
                    waitCnt++;
                end
            end else begin
                waitCnt = 0;
            end
        end
    end

    // Monitor: grants, payload stability, idle gap, routed responses and read-data gating.
    initial begin : monitor
        grant_t      g;
        grant_t      latched;
        resp_t       r;
        logic        prevExtValid;
        logic        prevReady;
        logic [31:0] rdata;
        prevExtValid   = 1'b0;
        prevReady      = 1'b0;
        latched.instr  = 1'b0;
        latched.addr   = '0;
        latched.wdata  = '0;
        latched.strobe = '0;
        forever begin
            @(negedge clk);
            if (prevReady) checkOutput("idle_gap_ext_valid", 32'(ext_valid), 32'h0);
            if (ext_valid && !prevExtValid) begin
                if (expGrantQ.size() == 0) begin
                    reportFail("unexpected_grant");
                end else begin
                    g = expGrantQ.pop_front();
                    checkOutput("grant_instruction", 32'(ext_instruction), 32'(g.instr));
                    checkOutput("grant_address", ext_address, g.addr);
                    checkOutput("grant_write_data", ext_write_data, g.wdata);
                    checkOutput("grant_strobe", 32'(ext_write_strobe), 32'(g.strobe));
                    latched = g;
                end
            end else if (ext_valid) begin
                checkOutput("hold_address", ext_address, latched.addr);
                checkOutput("hold_write_data", ext_write_data, latched.wdata);
                checkOutput("hold_strobe", 32'(ext_write_strobe), 32'(latched.strobe));
            end
            if (i_ready && d_ready) reportFail("both_ready");
            if (i_ready || d_ready) begin
                if (expRespQ.size() == 0) begin
                    reportFail("unexpected_ready");
                end else begin
                    r = expRespQ.pop_front();
                    rdata = i_ready ? i_read_data : d_read_data;
                    checkOutput("resp_master_is_instr", 32'(i_ready), 32'(r.instr));
                    checkOutput("resp_data", rdata, r.data);
                end
            end
            if (!i_ready) checkOutput("i_read_data_gated", i_read_data, 32'h0);
            if (!d_ready) checkOutput("d_read_data_gated", d_read_data, 32'h0);
            prevExtValid = ext_valid;
            prevReady    = i_ready | d_ready;
        end
    end

    // Directed sequence.
    initial begin : mainSeq
        int n;
        total      = 0;
        bad        = 0;
        reset      = 1'b1;
        slaveMode  = 0;
        slaveDelay = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkAllIdle("reset");
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] single fetch");
        expectGrant(1'b1, 32'h8000_0000, 32'h0, 4'h0);
        expectResp(1'b1, 32'h0000_0013);
        applyStimulus(1'b1, 32'h8000_0000, 32'h0, 4'h0, 0, 0);
        waitDrain("single_fetch");

        $display("[TB] collision");
        expectGrant(1'b0, 32'h8000_1000, 32'hDEAD_BEEF, 4'hF);
        expectGrant(1'b1, 32'h8000_0040, 32'h0, 4'h0);
        expectResp(1'b0, 32'h1000_0013);
        expectResp(1'b1, 32'h0040_0013);
        applyStimulus(1'b0, 32'h8000_1000, 32'hDEAD_BEEF, 4'hF, 0, 0);
        applyStimulus(1'b1, 32'h8000_0040, 32'h0, 4'h0, 0, 0);
        waitDrain("collision");

        $display("[TB] starvation");
        slaveDelay = 0;
        expectGrant(1'b0, 32'h0000_0100, 32'h0000_0000, 4'hF);
        expectGrant(1'b0, 32'h0000_0104, 32'h0000_0001, 4'h0);
        expectGrant(1'b0, 32'h0000_0108, 32'h0000_0002, 4'h3);
        expectGrant(1'b0, 32'h0000_010C, 32'h0000_0003, 4'h0);
        expectGrant(1'b1, 32'h8000_0200, 32'h0, 4'h0);
        expectGrant(1'b0, 32'h0000_0110, 32'h0000_0004, 4'hC);
        expectResp(1'b0, 32'h0100_0013);
        expectResp(1'b0, 32'h0104_0013);
        expectResp(1'b0, 32'h0108_0013);
        expectResp(1'b0, 32'h010C_0013);
        expectResp(1'b1, 32'h0200_0013);
        expectResp(1'b0, 32'h0110_0013);
        applyStimulus(1'b0, 32'h0000_0100, 32'h0000_0000, 4'hF, 0, 0);
        applyStimulus(1'b0, 32'h0000_0104, 32'h0000_0001, 4'h0, 0, 0);
        applyStimulus(1'b0, 32'h0000_0108, 32'h0000_0002, 4'h3, 0, 0);
        applyStimulus(1'b0, 32'h0000_010C, 32'h0000_0003, 4'h0, 0, 0);
        applyStimulus(1'b0, 32'h0000_0110, 32'h0000_0004, 4'hC, 0, 0);
        applyStimulus(1'b1, 32'h8000_0200, 32'h0, 4'h0, 0, 0);
        waitDrain("starvation");

        $display("[TB] collision after fairness window cleared");
        slaveDelay = 1;
        expectGrant(1'b0, 32'h8000_1800, 32'h0BAD_F00D, 4'h1);
        expectGrant(1'b1, 32'h8000_0300, 32'h0, 4'h0);
        expectResp(1'b0, 32'h1800_0013);
        expectResp(1'b1, 32'h0300_0013);
        applyStimulus(1'b0, 32'h8000_1800, 32'h0BAD_F00D, 4'h1, 0, 0);
        applyStimulus(1'b1, 32'h8000_0300, 32'h0, 4'h0, 0, 0);
        waitDrain("collision2");

        $display("[TB] payload stability");
        slaveDelay = 5;
        expectGrant(1'b0, 32'h8000_2000, 32'hCAFE_0001, 4'h3);
        expectResp(1'b0, 32'h2000_0013);
        applyStimulus(1'b0, 32'h8000_2000, 32'hCAFE_0001, 4'h3, 0, 2);
        waitDrain("stability");

        $display("[TB] reset mid-transaction and stray ready");
        slaveMode = 2;
        expectGrant(1'b0, 32'h8000_3000, 32'h1111_2222, 4'hF);
        applyStimulus(1'b0, 32'h8000_3000, 32'h1111_2222, 4'hF, 2, 0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ext_valid && n < 20);
        if (!ext_valid) reportFail("reset_test_no_grant");
        @(posedge clk); #1;
        reset     = 1'b1;
        slaveMode = 1;
        @(negedge clk);
        checkOutput("reset_wins_d_ready", 32'(d_ready), 32'h0);
        checkOutput("reset_wins_d_read_data", d_read_data, 32'h0);
        checkOutput("reset_wins_i_ready", 32'(i_ready), 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checkAllIdle("mid_reset");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("stray_ready_i_ready", 32'(i_ready), 32'h0);
            checkOutput("stray_ready_d_ready", 32'(d_ready), 32'h0);
            checkOutput("stray_ready_ext_valid", 32'(ext_valid), 32'h0);
        end
        @(posedge clk); #1;
        slaveMode = 0;
        @(negedge clk);

        $display("[TB] recovery load");
        slaveDelay = 0;
        expectGrant(1'b0, 32'h8000_4000, 32'h0, 4'h0);
        expectResp(1'b0, 32'h4000_0013);
        applyStimulus(1'b0, 32'h8000_4000, 32'h0, 4'h0, 0, 0);
        waitDrain("recovery");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
